// File: rtl/dual_port_request_arbiter_if.sv
// Request/response and RAM-port bundle between the requesters, the arbiter
// and a true dual-port block-RAM macro.
interface dual_port_request_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 1
);
  logic [NREQ-1:0]        req_v;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_d;
  logic [NREQ-1:0]        req_rdy;
  logic [NREQ-1:0]        rsp_v;
  logic [NREQ*DATA_W-1:0] rsp_d;
  logic [ADDR_W-1:0]      a0, a1;
  logic [DATA_W-1:0]      d0, d1;
  logic                   ce0, ce1, we0, we1, wem0, wem1;
  logic [DATA_W-1:0]      q0, q1;

  modport master (
    output req_v, req_we, req_a, req_d, q0, q1,
    input  req_rdy, rsp_v, rsp_d, a0, a1, d0, d1, ce0, ce1, we0, we1, wem0, wem1
  );

  modport slave (
    input  req_v, req_we, req_a, req_d, q0, q1,
    output req_rdy, rsp_v, rsp_d, a0, a1, d0, d1, ce0, ce1, we0, we1, wem0, wem1
  );
endinterface

// File: rtl/dual_port_request_arbiter.sv
// Round-robin arbiter mapping NREQ requesters onto the two ports of a dual-port
// RAM macro, blocking same-address write hazards and routing read data back.
module dual_port_request_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  dual_port_request_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ADDR_W-1:0] req_a_arr [NREQ];
  logic [DATA_W-1:0] req_d_arr [NREQ];
  logic [NREQ-1:0]   rsp_v_reg, rsp_v_next;
  logic [DATA_W-1:0] rsp_d_reg [NREQ];
  logic [DATA_W-1:0] rsp_d_next [NREQ];
  logic              g0_found, g1_found;
  logic [PTR_W-1:0]  g0_idx, g1_idx, last_idx, scan_idx;
  int                scan_int;
  logic              we0, we1;
  logic              pend0_reg, pend1_reg;
  logic [PTR_W-1:0]  id0_reg, id1_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_a_arr[gi] = bus.req_a[gi*ADDR_W +: ADDR_W];
      assign req_d_arr[gi] = bus.req_d[gi*DATA_W +: DATA_W];
      assign bus.req_rdy[gi] = (g0_found && (g0_idx == PTR_W'(gi))) ||
                               (g1_found && (g1_idx == PTR_W'(gi)));
      assign bus.rsp_d[gi*DATA_W +: DATA_W] = rsp_d_reg[gi];
    end
  endgenerate

  // Scan from rr_ptr with an explicit wrap so non-power-of-2 NREQ works.
  // Port 1 skips any requester that would hit the port-0 address with a write.
  always_comb begin
    g0_found = 1'b0;
    g0_idx   = '0;
    g1_found = 1'b0;
    g1_idx   = '0;
    scan_int = 0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_int = int'(rr_ptr_reg) + k;
      if (scan_int >= NREQ) scan_int = scan_int - NREQ;
      scan_idx = PTR_W'(scan_int);
      if (rst_n && bus.req_v[scan_idx]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = scan_idx;
        end else if (!g1_found &&
                     !((req_a_arr[scan_idx] == req_a_arr[g0_idx]) &&
                       (bus.req_we[scan_idx] || bus.req_we[g0_idx]))) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end
      end
    end
  end

  assign we0      = g0_found & bus.req_we[g0_idx];
  assign we1      = g1_found & bus.req_we[g1_idx];
  assign bus.ce0  = g0_found;
  assign bus.ce1  = g1_found;
  assign bus.we0  = we0;
  assign bus.we1  = we1;
  assign bus.wem0 = we0;
  assign bus.wem1 = we1;
  assign bus.a0   = g0_found ? req_a_arr[g0_idx] : '0;
  assign bus.a1   = g1_found ? req_a_arr[g1_idx] : '0;
  assign bus.d0   = g0_found ? req_d_arr[g0_idx] : '0;
  assign bus.d1   = g1_found ? req_d_arr[g1_idx] : '0;
  assign bus.rsp_v = rsp_v_reg;

  always_comb begin
    last_idx    = g1_found ? g1_idx : g0_idx;
    rr_ptr_next = rr_ptr_reg;
    if (g0_found) begin
      rr_ptr_next = (int'(last_idx) == NREQ - 1) ? '0 : last_idx + 1'b1;
    end
    // Each requester holds at most one grant per cycle, so the two ports never collide here.
    rsp_v_next = '0;
    rsp_d_next = rsp_d_reg;
    if (pend0_reg) begin
      rsp_v_next[id0_reg] = 1'b1;
      rsp_d_next[id0_reg] = bus.q0;
    end
    if (pend1_reg) begin
      rsp_v_next[id1_reg] = 1'b1;
      rsp_d_next[id1_reg] = bus.q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      rsp_v_reg  <= '0;
      rsp_d_reg  <= '{default: '0};
      pend0_reg  <= 1'b0;
      pend1_reg  <= 1'b0;
      id0_reg    <= '0;
      id1_reg    <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      rsp_v_reg  <= rsp_v_next;
      rsp_d_reg  <= rsp_d_next;
      pend0_reg  <= g0_found & ~we0;
      pend1_reg  <= g1_found & ~we1;
      id0_reg    <= g0_idx;
      id1_reg    <= g1_idx;
    end
  end
endmodule

// File: tb/tb_dual_port_request_arbiter.sv
// Bench for dual_port_request_arbiter: dual-port RAM model, behavioural
// reference checked every cycle, directed scenarios and random traffic.
module tb_dual_port_request_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 1;
  localparam int PW     = ADDR_W + DATA_W + 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dual_port_request_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dual_port_request_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // RAM macro: one-cycle read latency, writes take effect at the edge
  logic [DATA_W-1:0] ram   [2**ADDR_W];
  logic [DATA_W-1:0] m_mem [2**ADDR_W];
  logic [DATA_W-1:0] q0_reg = '0;
  logic [DATA_W-1:0] q1_reg = '0;
  assign bus.q0 = q0_reg;
  assign bus.q1 = q1_reg;

  always @(posedge clk) begin
    if (bus.ce0) begin
      if (bus.we0 && bus.wem0) ram[bus.a0] = bus.d0;
      else q0_reg <= ram[bus.a0];
    end
    if (bus.ce1) begin
      if (bus.we1 && bus.wem1) ram[bus.a1] = bus.d1;
      else q1_reg <= ram[bus.a1];
    end
  end

  // Reference model state
  int                m_rr;
  logic [NREQ-1:0]   m_rsp_v;
  logic [DATA_W-1:0] m_rsp_d [NREQ];
  int                st_n;
  int                st_id  [2];
  logic [DATA_W-1:0] st_dat [2];
  int                m_g0, m_g1;
  logic [NREQ-1:0]   exp_rdy;
  logic [ADDR_W-1:0] m_a  [NREQ];
  logic              m_we [NREQ];
  logic [DATA_W-1:0] m_d  [NREQ];
  int                order[$];
  logic [NREQ*DATA_W-1:0] exp_rsp_d;
  logic [PW-1:0]     exp_p0, exp_p1;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) exp_rsp_d[i*DATA_W +: DATA_W] = m_rsp_d[i];
    if (!rst_n) begin
      m_rr    = 0;
      m_rsp_v = '0;
      st_n    = 0;
      m_g0    = -1;
      m_g1    = -1;
      exp_rdy = '0;
      for (int i = 0; i < NREQ; i++) m_rsp_d[i] = '0;
      check("reset_rdy", bus.req_rdy, 0);
      check("reset_ports", {bus.ce1, bus.ce0, bus.we1, bus.we0}, 0);
      check("reset_rsp_v", bus.rsp_v, 0);
      check("reset_rsp_d", bus.rsp_d, 0);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        m_a[i]  = bus.req_a[i*ADDR_W +: ADDR_W];
        m_we[i] = bus.req_we[i];
        m_d[i]  = bus.req_d[i*DATA_W +: DATA_W];
      end
      // valid requesters in priority order, first to port 0, first hazard-free to port 1
      order.delete();
      for (int k = 0; k < NREQ; k++)
        if (bus.req_v[(m_rr + k) % NREQ]) order.push_back((m_rr + k) % NREQ);
      m_g0 = -1;
      m_g1 = -1;
      if (order.size() > 0) begin
        m_g0 = order.pop_front();
        foreach (order[j])
          if (m_g1 < 0 && !(m_a[order[j]] == m_a[m_g0] && (m_we[order[j]] || m_we[m_g0])))
            m_g1 = order[j];
      end
      exp_rdy = '0;
      if (m_g0 >= 0) exp_rdy[m_g0] = 1'b1;
      if (m_g1 >= 0) exp_rdy[m_g1] = 1'b1;
      exp_p0 = (m_g0 >= 0) ? {1'b1, m_we[m_g0], m_we[m_g0], m_a[m_g0], m_d[m_g0]} : '0;
      exp_p1 = (m_g1 >= 0) ? {1'b1, m_we[m_g1], m_we[m_g1], m_a[m_g1], m_d[m_g1]} : '0;
      check("rdy", bus.req_rdy, exp_rdy);
      check("port0", {bus.ce0, bus.we0, bus.wem0, bus.a0, bus.d0}, exp_p0);
      check("port1", {bus.ce1, bus.we1, bus.wem1, bus.a1, bus.d1}, exp_p1);
      check("rsp_v", bus.rsp_v, m_rsp_v);
      check("rsp_d", bus.rsp_d, exp_rsp_d);
      // advance to the state after the coming edge
      m_rsp_v = '0;
      for (int s = 0; s < st_n; s++) begin
        m_rsp_v[st_id[s]] = 1'b1;
        m_rsp_d[st_id[s]] = st_dat[s];
      end
      st_n = 0;
      if (m_g0 >= 0 && !m_we[m_g0]) begin st_id[st_n] = m_g0; st_dat[st_n] = m_mem[m_a[m_g0]]; st_n++; end
      if (m_g1 >= 0 && !m_we[m_g1]) begin st_id[st_n] = m_g1; st_dat[st_n] = m_mem[m_a[m_g1]]; st_n++; end
      if (m_g0 >= 0 && m_we[m_g0]) m_mem[m_a[m_g0]] = m_d[m_g0];
      if (m_g1 >= 0 && m_we[m_g1]) m_mem[m_a[m_g1]] = m_d[m_g1];
      if (m_g1 >= 0) m_rr = (m_g1 + 1) % NREQ;
      else if (m_g0 >= 0) m_rr = (m_g0 + 1) % NREQ;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.req_v[i]  = v;
    bus.req_we[i] = we;
    bus.req_a[i*ADDR_W +: ADDR_W] = a;
    bus.req_d[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  logic [NREQ-1:0] granted;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(16 + i), '0);

    // reset with everyone requesting, then first grants after release
    smp();
    check("t1_rdy_in_reset", bus.req_rdy, 4'b0000);
    check("t1_ce_in_reset", {bus.ce1, bus.ce0}, 2'b00);
    check("t1_rsp_v_in_reset", bus.rsp_v, 4'b0000);
    cyc();
    rst_n = 1'b1;
    smp();
    check("t1_first_grant", bus.req_rdy, 4'b0011);
    check("t1_a1", bus.a1, 14'h11);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    smp();
    check("t1_second_grant", bus.req_rdy, 4'b1100);
    cyc();
    idle();
    repeat (3) cyc();

    // write 1 to 0x0005 via req2, read it back via req3
    set_req(2, 1'b1, 1'b1, 14'h0005, 1'b1);
    smp();
    check("t2_wr_grant", bus.req_rdy, 4'b0100);
    check("t2_we0", {bus.we0, bus.wem0}, 2'b11);
    cyc();
    set_req(2, 1'b0, 1'b0, '0, '0);
    set_req(3, 1'b1, 1'b0, 14'h0005, '0);
    smp();
    check("t2_rd_grant", bus.req_rdy, 4'b1000);
    cyc();
    idle();
    smp();
    check("t2_rsp_v_early", bus.rsp_v, 4'b0000);
    smp();
    check("t2_rsp_v", bus.rsp_v, 4'b1000);
    check("t2_rsp_d3", bus.rsp_d[3*DATA_W +: DATA_W], 1);
    smp();
    check("t2_rsp_v_pulse_end", bus.rsp_v, 4'b0000);

    // write/read hazard on 0x0100 from rr_ptr=0
    cyc();
    set_req(0, 1'b1, 1'b1, 14'h0100, 1'b1);
    set_req(1, 1'b1, 1'b0, 14'h0100, '0);
    smp();
    check("t3_hazard_grant", bus.req_rdy, 4'b0001);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    smp();
    check("t3_deferred_grant", bus.req_rdy, 4'b0010);
    cyc();
    idle();
    smp();
    smp();
    check("t3_rsp_v", bus.rsp_v, 4'b0010);
    check("t3_rsp_d1", bus.rsp_d[1*DATA_W +: DATA_W], 1);

    // continuous reads from everyone: pairs alternate
    cyc();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 15)), '0);
    for (int c = 0; c < 6; c++) begin
      smp();
      check("t4_pair", bus.req_rdy, (c % 2 == 0) ? 4'b1100 : 4'b0011);
      check("t4_model_rr", m_rr, (c % 2 == 0) ? 0 : 2);
      granted = bus.req_rdy;
      cyc();
      if (c == 5) idle();
      else for (int i = 0; i < NREQ; i++)
        if (granted[i]) set_req(i, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 15)), '0);
    end

    // pointer wrap: move rr_ptr to 3, then req3 and req0 compete
    set_req(2, 1'b1, 1'b0, 14'h0003, '0);
    smp();
    check("t5_single", bus.req_rdy, 4'b0100);
    check("t5_model_rr3", m_rr, 3);
    cyc();
    set_req(2, 1'b0, 1'b0, '0, '0);
    set_req(3, 1'b1, 1'b0, 14'h0020, '0);
    set_req(0, 1'b1, 1'b0, 14'h0021, '0);
    smp();
    check("t5_wrap_grant", bus.req_rdy, 4'b1001);
    check("t5_model_grant", exp_rdy, 4'b1001);
    check("t5_a0_req3", bus.a0, 14'h0020);
    check("t5_a1_req0", bus.a1, 14'h0021);
    check("t5_model_rr1", m_rr, 1);
    cyc();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(40 + i), '0);
    smp();
    check("t5_after_wrap", bus.req_rdy, 4'b0110);
    cyc();
    idle();
    repeat (3) cyc();

    // reset between a read handshake and its response
    set_req(0, 1'b1, 1'b0, 14'h0005, '0);
    smp();
    check("t6_grant", bus.req_rdy, 4'b0001);
    cyc();
    idle();
    rst_n = 1'b0;
    smp();
    check("t6_rsp_v_in_reset", bus.rsp_v, 4'b0000);
    cyc();
    rst_n = 1'b1;
    smp();
    check("t6_rsp_v_after", bus.rsp_v, 4'b0000);
    check("t6_rsp_d_after", bus.rsp_d, 4'b0000);
    smp();
    check("t6_rsp_v_later", bus.rsp_v, 4'b0000);

    // random traffic on a small address window, requests held until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      granted = bus.req_rdy;
      cyc();
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_v[i] && !granted[i])) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                    DATA_W'($urandom_range(0, 1)));
          else
            set_req(i, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    rst_n = 1'b1;
    idle();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
